// File: rtl/nrf_tx_controller_if.sv
// Payload stream and SPI byte bus between nrf_tx_controller and its neighbours.
// master = controller side, slave = upstream source / SPI master side.
interface nrf_tx_controller_if;
  logic [7:0] i_Pay_Byte;
  logic       i_Pay_Valid;
  logic       o_Pay_Ready;
  logic       i_TX_Ready;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_SPI_Csn;

  modport master (
    input  i_Pay_Byte, i_Pay_Valid,
    input  i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_Pay_Ready, o_TX_DV, o_TX_Byte,
    output o_SPI_Csn
  );

  modport slave (
    output i_Pay_Byte, i_Pay_Valid,
    output i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_Pay_Ready, o_TX_DV, o_TX_Byte,
    input  o_SPI_Csn
  );
endinterface

// File: rtl/nrf_tx_controller.sv
// nRF24 packet transmit sequencer: W_TX_PAYLOAD, CE pulse, IRQ wait, status.
// Optional NRF_TX_FLUSH_ON_FAIL_EN sends FLUSH_TX after a MAX_RT outcome.
module nrf_tx_controller #(
  parameter int PAYLOAD_LEN        = 32,
  parameter int CE_PULSE_CYCLES    = 250,
  parameter int IRQ_TIMEOUT_CYCLES = 2500000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_Start,
  input  logic                      i_IRQ_n,
  nrf_tx_controller_if.master       bus,
  output logic                      o_CE,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Fail,
  output logic [7:0]                o_Status
);

  localparam int CE_W = $clog2(CE_PULSE_CYCLES + 1);
  localparam int TO_W = $clog2(IRQ_TIMEOUT_CYCLES + 1);

  localparam logic [5:0]      LAST_BYTE = 6'(PAYLOAD_LEN - 1);
  localparam logic [CE_W-1:0] CE_LAST   = CE_W'(CE_PULSE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(IRQ_TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX    = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CSN_GAP,
    S_CE_PULSE,
    S_WAIT_IRQ,
    S_RD_STATUS,
    S_CLR_FLAGS,
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
    S_FLUSH,
`endif
    S_REPORT
  } state_t;

  state_t          r_State;
  state_t          r_Next;
  logic            r_Wait;
  logic            r_Gap;
  logic [5:0]      r_Byte_Cnt;
  logic [CE_W-1:0] r_Ce_Cnt;
  logic [TO_W-1:0] r_To_Cnt;
  logic            r_Csn;
  logic            r_CE;
  logic            r_TX_DV;
  logic [7:0]      r_TX_Byte;
  logic            r_Pay_Ready;
  logic            r_Busy;
  logic            r_Done;
  logic            r_Fail;
  logic [7:0]      r_Status;
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
  logic            r_Flushed;
`endif

  logic       w_Send;
  logic [7:0] w_Cmd;
  logic       w_Issue;
  logic       w_Rx;

  // Which byte the current state wants on MOSI, and whether it is ready
  always_comb begin
    w_Send = 1'b0;
    w_Cmd  = 8'h00;
    case (r_State)
      S_CMD: begin
        w_Send = 1'b1;
        w_Cmd  = 8'hA0;
      end
      S_PAYLOAD: begin
        w_Send = bus.i_Pay_Valid;
        w_Cmd  = bus.i_Pay_Byte;
      end
      S_RD_STATUS: begin
        w_Send = 1'b1;
        w_Cmd  = 8'h27;
      end
      S_CLR_FLAGS: begin
        w_Send = 1'b1;
        w_Cmd  = 8'h70;
      end
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
      S_FLUSH: begin
        w_Send = 1'b1;
        w_Cmd  = 8'hE1;
      end
`endif
      default: ;
    endcase
  end

  assign w_Issue = w_Send && !r_Wait && bus.i_TX_Ready;
  assign w_Rx    = r_Wait && bus.i_RX_DV;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= S_IDLE;
      r_Next      <= S_IDLE;
      r_Wait      <= 1'b0;
      r_Gap       <= 1'b0;
      r_Byte_Cnt  <= '0;
      r_Ce_Cnt    <= '0;
      r_To_Cnt    <= '0;
      r_Csn       <= 1'b1;
      r_CE        <= 1'b0;
      r_TX_DV     <= 1'b0;
      r_TX_Byte   <= 8'h00;
      r_Pay_Ready <= 1'b0;
      r_Busy      <= 1'b0;
      r_Done      <= 1'b0;
      r_Fail      <= 1'b0;
      r_Status    <= 8'h00;
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
      r_Flushed   <= 1'b0;
`endif
    end else begin
      r_TX_DV     <= 1'b0;
      r_Pay_Ready <= 1'b0;
      r_Done      <= 1'b0;
      r_Fail      <= 1'b0;

      // One byte in flight at most: issue, then hold until its RX_DV
      if (w_Issue) begin
        r_TX_DV     <= 1'b1;
        r_TX_Byte   <= w_Cmd;
        r_Pay_Ready <= (r_State == S_PAYLOAD);
        r_Wait      <= 1'b1;
      end else if (w_Rx) begin
        r_Wait <= 1'b0;
      end

      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_Busy     <= 1'b1;
            r_Csn      <= 1'b0;
            r_Byte_Cnt <= '0;
            r_State    <= S_CMD;
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
            r_Flushed  <= 1'b0;
`endif
          end
        end
        S_CMD: begin
          if (w_Rx) r_State <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_Rx) begin
            if (r_Byte_Cnt == LAST_BYTE) begin
              r_Csn   <= 1'b1;
              r_Gap   <= 1'b0;
              r_Next  <= S_CE_PULSE;
              r_State <= S_CSN_GAP;
            end else begin
              r_Byte_Cnt <= r_Byte_Cnt + 6'd1;
            end
          end
        end
        S_CSN_GAP: begin
          if (r_Gap) begin
            r_State <= r_Next;
            if (r_Next == S_CE_PULSE) begin
              r_CE     <= 1'b1;
              r_Ce_Cnt <= '0;
            end
          end else begin
            r_Gap <= 1'b1;
          end
        end
        S_CE_PULSE: begin
          if (r_Ce_Cnt == CE_LAST) begin
            r_CE     <= 1'b0;
            r_To_Cnt <= '0;
            r_State  <= S_WAIT_IRQ;
          end else begin
            r_Ce_Cnt <= r_Ce_Cnt + CE_W'(1);
          end
        end
        S_WAIT_IRQ: begin
          if (!i_IRQ_n) begin
            r_Csn   <= 1'b0;
            r_State <= S_RD_STATUS;
          end else if (r_To_Cnt >= TO_LAST) begin
            r_Fail  <= 1'b1;
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end else if (r_To_Cnt != TO_MAX) begin
            r_To_Cnt <= r_To_Cnt + TO_W'(1);
          end
        end
        S_RD_STATUS: begin
          if (w_Rx) begin
            r_Status <= bus.i_RX_Byte;
            r_State  <= S_CLR_FLAGS;
          end
        end
        S_CLR_FLAGS: begin
          if (w_Rx) begin
            r_Csn   <= 1'b1;
            r_Gap   <= 1'b0;
            r_Next  <= S_REPORT;
            r_State <= S_CSN_GAP;
          end
        end
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
        S_FLUSH: begin
          if (w_Rx) begin
            r_Csn     <= 1'b1;
            r_Gap     <= 1'b0;
            r_Flushed <= 1'b1;
            r_Next    <= S_REPORT;
            r_State   <= S_CSN_GAP;
          end
        end
`endif
        S_REPORT: begin
          // TX_DS wins when both TX_DS and MAX_RT are set
          if (r_Status[5]) begin
            r_Done  <= 1'b1;
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
          else if (r_Status[4] && !r_Flushed) begin
            r_Csn   <= 1'b0;
            r_State <= S_FLUSH;
          end
`endif
          else begin
            r_Fail  <= 1'b1;
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign bus.o_SPI_Csn   = r_Csn;
  assign bus.o_TX_DV     = r_TX_DV;
  assign bus.o_TX_Byte   = r_TX_Byte;
  assign bus.o_Pay_Ready = r_Pay_Ready;
  assign o_CE            = r_CE;
  assign o_Busy          = r_Busy;
  assign o_Done          = r_Done;
  assign o_Fail          = r_Fail;
  assign o_Status        = r_Status;

endmodule

// File: tb/tb_nrf_tx_controller.sv
// Directed bench for nrf_tx_controller with SPI, payload and IRQ responders.
// Build with NRF_TX_FLUSH_ON_FAIL_EN to expect the FLUSH_TX frame.
module tb_nrf_tx_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       irq_n;
  logic       o_CE;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Fail;
  logic [7:0] o_Status;

  nrf_tx_controller_if bus ();

  nrf_tx_controller #(
    .PAYLOAD_LEN        (4),
    .CE_PULSE_CYCLES    (250),
    .IRQ_TIMEOUT_CYCLES (1000)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Start  (start),
    .i_IRQ_n  (irq_n),
    .bus      (bus),
    .o_CE     (o_CE),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done),
    .o_Fail   (o_Fail),
    .o_Status (o_Status)
  );

  logic [7:0] status_ret = 8'h2E;
  bit         irq_never  = 1'b0;
  bit         stall_en   = 1'b0;

  int cyc         = 0;
  int ce_hi       = 0;
  int done_n      = 0;
  int fail_n      = 0;
  int frames      = 0;
  int fail_cyc    = 0;
  int ce_fall_cyc = 0;
  int viol_spi    = 0;
  int viol_stall  = 0;
  int stall_cyc   = 0;
  logic ce_prev   = 1'b0;
  logic csn_prev  = 1'b1;
  logic [7:0] mosi_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // SPI master responder: 3-cycle byte, logs MOSI, returns status on 0x27
  initial begin
    int cnt;
    logic sbusy;
    logic [7:0] resp;
    cnt = 0;
    sbusy = 1'b0;
    resp = 8'h00;
    bus.i_TX_Ready = 1'b1;
    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = 8'h00;
    forever begin
      @(negedge clk);
      bus.i_RX_DV = 1'b0;
      if (bus.o_TX_DV) begin
        if (sbusy || bus.o_SPI_Csn) viol_spi++;
        mosi_q.push_back(bus.o_TX_Byte);
        resp = (bus.o_TX_Byte == 8'h27) ? status_ret : 8'h0E;
        sbusy = 1'b1;
        cnt = 3;
        bus.i_TX_Ready = 1'b0;
      end else if (sbusy) begin
        cnt--;
        if (cnt == 0) begin
          sbusy = 1'b0;
          bus.i_RX_DV = 1'b1;
          bus.i_RX_Byte = resp;
          bus.i_TX_Ready = 1'b1;
        end
      end
    end
  end

  // Upstream payload source: 11 22 33 44, optional 20-cycle stall after byte 2
  initial begin
    int idx;
    int sc;
    idx = 0;
    sc = 0;
    bus.i_Pay_Valid = 1'b0;
    bus.i_Pay_Byte = 8'h11;
    forever begin
      @(negedge clk);
      if (sc > 0) begin
        stall_cyc++;
        if (bus.o_TX_DV || bus.o_SPI_Csn) viol_stall++;
        sc--;
      end
      if (!o_Busy) begin
        idx = 0;
      end else if (bus.o_Pay_Ready) begin
        idx++;
        if (stall_en && idx == 2) sc = 20;
      end
      bus.i_Pay_Valid = (sc == 0) && (idx < 4);
      bus.i_Pay_Byte = 8'((idx + 1) * 17);
    end
  end

  // Radio IRQ: low 50 cycles after CE falls, released when the block goes idle
  initial begin
    int ic;
    bit armed;
    logic ce_p;
    ic = 0;
    armed = 1'b0;
    ce_p = 1'b0;
    irq_n = 1'b1;
    forever begin
      @(negedge clk);
      if (!o_Busy) begin
        irq_n = 1'b1;
        armed = 1'b0;
      end else if (ce_p && !o_CE && !irq_never) begin
        armed = 1'b1;
        ic = 50;
      end else if (armed) begin
        if (ic > 0) ic--;
        else irq_n = 1'b0;
      end
      ce_p = o_CE;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (o_CE) ce_hi++;
      if (o_Done) done_n++;
      if (o_Fail) begin
        fail_n++;
        fail_cyc = cyc;
      end
      if (ce_prev && !o_CE) ce_fall_cyc = cyc;
      if (csn_prev && !bus.o_SPI_Csn) frames++;
      ce_prev = o_CE;
      csn_prev = bus.o_SPI_Csn;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int d0, input int f0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (done_n != d0 || fail_n != f0) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  function automatic logic [63:0] mosi_pack(input int base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (base + i < mosi_q.size()) v = {v[55:0], mosi_q[base + i]};
      else v = {v[55:0], 8'h00};
    end
    return v;
  endfunction

  initial begin
    int b;
    int d;
    int f;
    int c;
    int fr;
    int s;
    bit seen;

    rst = 1'b1;
    start = 1'b0;
    tick(3);
    chk("rst_csn",   64'(bus.o_SPI_Csn),   64'd1);
    chk("rst_ce",    64'(o_CE),            64'd0);
    chk("rst_txdv",  64'(bus.o_TX_DV),     64'd0);
    chk("rst_txbyte",64'(bus.o_TX_Byte),   64'h00);
    chk("rst_pready",64'(bus.o_Pay_Ready), 64'd0);
    chk("rst_busy",  64'(o_Busy),          64'd0);
    chk("rst_done",  64'(o_Done),          64'd0);
    chk("rst_fail",  64'(o_Fail),          64'd0);
    chk("rst_status",64'(o_Status),        64'h00);
    rst = 1'b0;
    tick(2);

    // Successful packet, with a second start while busy
    status_ret = 8'h2E;
    b = mosi_q.size(); d = done_n; f = fail_n; c = ce_hi; fr = frames;
    pulse_start();
    tick(10);
    pulse_start();
    wait_end("a_end", d, f);
    tick(400);
    chk("a_nbytes", 64'(mosi_q.size() - b), 64'd7);
    chk("a_mosi",   mosi_pack(b, 7), 64'h00A0112233442770);
    chk("a_ce_hi",  64'(ce_hi - c),  64'd250);
    chk("a_done",   64'(done_n - d), 64'd1);
    chk("a_fail",   64'(fail_n - f), 64'd0);
    chk("a_status", 64'(o_Status),   64'h2E);
    chk("a_busy",   64'(o_Busy),     64'd0);
    chk("a_frames", 64'(frames - fr),64'd2);

    // MAX_RT outcome
    status_ret = 8'h1E;
    b = mosi_q.size(); d = done_n; f = fail_n; fr = frames;
    pulse_start();
    wait_end("b_end", d, f);
    tick(50);
    chk("b_fail",   64'(fail_n - f), 64'd1);
    chk("b_done",   64'(done_n - d), 64'd0);
    chk("b_status", 64'(o_Status),   64'h1E);
`ifdef NRF_TX_FLUSH_ON_FAIL_EN
    chk("b_nbytes", 64'(mosi_q.size() - b), 64'd8);
    chk("b_mosi",   mosi_pack(b, 8), 64'hA0112233442770E1);
    chk("b_frames", 64'(frames - fr),64'd3);
`else
    chk("b_nbytes", 64'(mosi_q.size() - b), 64'd7);
    chk("b_mosi",   mosi_pack(b, 7), 64'h00A0112233442770);
    chk("b_frames", 64'(frames - fr),64'd2);
`endif

    // IRQ timeout
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("c_rst_status", 64'(o_Status), 64'h00);
    irq_never = 1'b1;
    b = mosi_q.size(); d = done_n; f = fail_n;
    pulse_start();
    wait_end("c_end", d, f);
    tick(20);
    chk("c_fail",    64'(fail_n - f), 64'd1);
    chk("c_done",    64'(done_n - d), 64'd0);
    chk("c_latency", 64'(fail_cyc - ce_fall_cyc), 64'd1000);
    chk("c_nbytes",  64'(mosi_q.size() - b), 64'd5);
    chk("c_status",  64'(o_Status), 64'h00);
    irq_never = 1'b0;

    // Upstream stall after byte 2
    status_ret = 8'h2E;
    stall_en = 1'b1;
    b = mosi_q.size(); d = done_n; f = fail_n; s = stall_cyc;
    pulse_start();
    wait_end("d_end", d, f);
    tick(20);
    stall_en = 1'b0;
    chk("d_stall_len", 64'(stall_cyc - s), 64'd20);
    chk("d_stall_bus", 64'(viol_stall),    64'd0);
    chk("d_done",      64'(done_n - d),    64'd1);
    chk("d_mosi",      mosi_pack(b, 7),    64'h00A0112233442770);

    // Reset during the CE pulse
    d = done_n; f = fail_n;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (o_CE) begin
        seen = 1'b1;
        break;
      end
    end
    chk("e_ce_rise", 64'(seen), 64'd1);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("e_ce",   64'(o_CE),          64'd0);
    chk("e_csn",  64'(bus.o_SPI_Csn), 64'd1);
    chk("e_busy", 64'(o_Busy),        64'd0);
    chk("e_done_now", 64'(o_Done),    64'd0);
    chk("e_fail_now", 64'(o_Fail),    64'd0);
    rst = 1'b0;
    tick(100);
    chk("e_no_pulse", 64'((done_n - d) + (fail_n - f)), 64'd0);
    b = mosi_q.size(); d = done_n; f = fail_n;
    pulse_start();
    wait_end("e_end", d, f);
    tick(10);
    chk("e_done", 64'(done_n - d),  64'd1);
    chk("e_mosi", mosi_pack(b, 7), 64'h00A0112233442770);

    chk("spi_protocol", 64'(viol_spi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nrf_tx_controller.md
NRF_TX_CONTROLLER -- requirements
Module: nrf_tx_controller

Interface
REQ-001 Parameter PAYLOAD_LEN, default 32: number of payload bytes per packet (1..32).
REQ-002 Parameter CE_PULSE_CYCLES, default 250: number of i_Clk cycles o_CE is held high (at least 10 us).
REQ-003 Parameter IRQ_TIMEOUT_CYCLES, default 2500000: maximum number of cycles to wait for IRQ before aborting.
REQ-004 i_Clk  in  1  single clock; all logic on posedge.
REQ-005 i_Rst  in  1  synchronous, active-high reset.
REQ-006 i_Start  in  1  one-cycle request to send one packet; ignored while o_Busy is high.
REQ-007 i_Pay_Byte  in  8  payload byte from upstream; valid when i_Pay_Valid is high.
REQ-008 i_Pay_Valid  in  1  upstream byte valid.
REQ-009 o_Pay_Ready  out  1  one-cycle pulse; the current payload byte is accepted.
REQ-010 i_TX_Ready  in  1  SPI master is able to accept a byte.
REQ-011 o_TX_DV  out  1  one-cycle pulse; o_TX_Byte is valid for the SPI master.
REQ-012 o_TX_Byte  out  8  byte to shift out on MOSI.
REQ-013 i_RX_DV  in  1  one-cycle pulse; the SPI byte has completed and i_RX_Byte is valid.
REQ-014 i_RX_Byte  in  8  byte captured from MISO.
REQ-015 o_SPI_Csn  out  1  radio chip select, active-low.
REQ-016 o_CE  out  1  radio CE pin.
REQ-017 i_IRQ_n  in  1  radio IRQ, active-low, already synchronised.
REQ-018 o_Busy  out  1  high from an accepted start until the done or fail pulse.
REQ-019 o_Done  out  1  one-cycle pulse; the radio reported TX_DS.
REQ-020 o_Fail  out  1  one-cycle pulse; the radio reported MAX_RT, or the IRQ wait timed out.
REQ-021 o_Status  out  8  last STATUS byte read from the radio; held until the next read.

Function
REQ-022 States: IDLE, CMD, PAYLOAD, CSN_GAP, CE_PULSE, WAIT_IRQ, RD_STATUS, CLR_FLAGS, [FLUSH], REPORT.
REQ-023 IDLE: when i_Start is high, set o_Busy, drive o_SPI_Csn low, and go to CMD.
REQ-024 Byte rule: pulse o_TX_DV only in a cycle where i_TX_Ready is high, then wait for i_RX_DV before issuing the next byte. At most one byte is outstanding at any time.
REQ-025 CMD sends 0xA0 (W_TX_PAYLOAD), then goes to PAYLOAD.
REQ-026 PAYLOAD, per byte:
  - wait until both i_Pay_Valid and i_TX_Ready are high;
  - pulse o_Pay_Ready and o_TX_DV in the same cycle, with o_TX_Byte equal to i_Pay_Byte.
REQ-027 PAYLOAD ends after PAYLOAD_LEN bytes, each completed by an i_RX_DV. o_SPI_Csn then goes high and the state becomes CSN_GAP.
REQ-028 Upstream starvation (i_Pay_Valid low) stalls the block indefinitely with CSN held low; it is not a timeout.
REQ-029 CSN_GAP holds o_SPI_Csn high for 2 cycles, then goes to CE_PULSE.
REQ-030 CE_PULSE holds o_CE high for exactly CE_PULSE_CYCLES cycles, then drives it low and goes to WAIT_IRQ.
REQ-031 WAIT_IRQ:
  - i_IRQ_n low: drive o_SPI_Csn low and go to RD_STATUS;
  - IRQ_TIMEOUT_CYCLES elapse with i_IRQ_n high: pulse o_Fail, clear o_Busy, go to IDLE.
  - o_Status is left unchanged on timeout.
REQ-032 RD_STATUS sends 0x27 (W_REGISTER|STATUS). The i_RX_Byte returned with that byte's i_RX_DV is latched into o_Status.
REQ-033 CLR_FLAGS sends 0x70 (clears RX_DR, TX_DS and MAX_RT), then drives o_SPI_Csn high.
REQ-034 REPORT, entered after a 2-cycle CSN gap:
  - o_Status[5] set: pulse o_Done;
  - otherwise, o_Status[4] set: pulse o_Fail;
  - neither bit set: pulse o_Fail;
  - both bits set: pulse o_Done only.
REQ-035 REPORT clears o_Busy in the same cycle as the pulse and returns to IDLE.
REQ-036 Counters:
  - the byte counter is 6 bits wide;
  - the CE and timeout counters are wide enough for their parameters;
  - the timeout counter saturates and never wraps.
REQ-037 The SPI bus is only touched while o_Busy is high; o_TX_DV is never high in IDLE.

Reset
REQ-038 Reset values: o_SPI_Csn=1, o_CE=0, o_TX_DV=0, o_TX_Byte=0x00, o_Pay_Ready=0, o_Busy=0, o_Done=0, o_Fail=0, o_Status=0x00; state=IDLE; all counters 0.
REQ-039 Reset asserted mid-operation (including mid-byte or mid-CE pulse) takes effect on the next clock edge:
  - CSN and CE are released immediately;
  - no done or fail pulse is generated.

Configuration
REQ-040 Macro NRF_TX_FLUSH_ON_FAIL_EN defined: on the MAX_RT outcome in REPORT, first assert CSN low and send 0xE1 (FLUSH_TX) in state FLUSH. Then raise CSN for a 2-cycle gap and pulse o_Fail.
REQ-041 Macro NRF_TX_FLUSH_ON_FAIL_EN undefined: the FLUSH state does not exist and o_Fail pulses directly; timeout failures never flush in either build.

Verification
REQ-042 PAYLOAD_LEN=4, payload 11 22 33 44, SPI model returns 0x2E on the 0x27 byte, IRQ low 50 cycles after CE falls:
  - MOSI byte sequence 0xA0,11,22,33,44 | 0x27,0x70;
  - o_CE high for exactly 250 cycles;
  - o_Done pulses once and o_Status equals 0x2E.
REQ-043 Same stimulus with a status return of 0x1E:
  - o_Fail pulses once;
  - with NRF_TX_FLUSH_ON_FAIL_EN, a third CSN frame containing 0xE1 precedes o_Fail;
  - without the macro, no 0xE1 is ever sent.
REQ-044 i_IRQ_n held high, IRQ_TIMEOUT_CYCLES=1000:
  - o_Fail pulses 1000 cycles after o_CE falls;
  - no STATUS frame is sent and o_Status remains 0x00.
REQ-045 Upstream i_Pay_Valid dropped for 20 cycles after byte 2:
  - no o_TX_DV during the stall and CSN stays low;
  - the packet then completes normally.
REQ-046 i_Rst pulsed while o_CE is high:
  - the next cycle shows o_CE=0, o_SPI_Csn=1, o_Busy=0 and no done or fail pulse;
  - a following i_Start runs a full packet.
REQ-047 i_Start pulsed while o_Busy is high is ignored: exactly one packet is sent.
